// File: rtl/rv_hazard_ctrl.sv
// rtl/rv_hazard_ctrl.sv - RV32I interlock: RAW scoreboard, redirect flush sequencing, stall/issue strobes
module rv_hazard_ctrl #(
   parameter int CNT_W        = 2,
   parameter int FLUSH_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        id_valid,
   input  logic [31:0] if_id_ir,
   input  logic        ex_redirect,
   input  logic        wb_valid,
   input  logic [4:0]  wb_rd,
   output logic        issue,
   output logic        stall,
   output logic        flush,
   output logic [31:0] sb_busy,
   output logic        sb_err
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam int               FC_W    = $clog2(FLUSH_CYCLES + 2);
   localparam logic [FC_W-1:0]  FC_LOAD = FC_W'(FLUSH_CYCLES);

   typedef enum logic {ST_RUN, ST_FLUSH} state_t;

   state_t           state_q, state_d;
   logic [FC_W-1:0]  fcnt_q, fcnt_d;
   logic [CNT_W-1:0] cnt_q [32];
   logic [CNT_W-1:0] cnt_d [32];
   logic             sb_err_q, sb_err_d;

   logic [6:0] opcode;
   logic [4:0] rd, rs1, rs2;
   logic       op_wr, op_rs1, op_rs2;
   logic       writes_rd, reads_rs1, reads_rs2;
   logic       rs1_ready, rs2_ready, rd_sat, hazard;
   logic       unused_ir;

   assign opcode    = if_id_ir[6:0];
   assign rd        = if_id_ir[11:7];
   assign rs1       = if_id_ir[19:15];
   assign rs2       = if_id_ir[24:20];
   assign unused_ir = ^{if_id_ir[31:25], if_id_ir[14:12]};

   // Opcode class decode; anything unrecognised behaves as a NOP
   always_comb begin
      op_wr  = 1'b0;
      op_rs1 = 1'b0;
      op_rs2 = 1'b0;
      case (opcode)
         7'b0110011: begin op_wr = 1'b1; op_rs1 = 1'b1; op_rs2 = 1'b1; end
         7'b0010011: begin op_wr = 1'b1; op_rs1 = 1'b1; end
         7'b0000011: begin op_wr = 1'b1; op_rs1 = 1'b1; end
         7'b0110111: op_wr = 1'b1;
         7'b0010111: op_wr = 1'b1;
         7'b1101111: op_wr = 1'b1;
         7'b1100111: begin op_wr = 1'b1; op_rs1 = 1'b1; end
         7'b0100011: begin op_rs1 = 1'b1; op_rs2 = 1'b1; end
         7'b1100011: begin op_rs1 = 1'b1; op_rs2 = 1'b1; end
         default: ;
      endcase
   end

   // Hazard detection; a same-cycle writeback retiring the last write makes the source readable
   always_comb begin
      writes_rd = op_wr  && (rd  != 5'd0);
      reads_rs1 = op_rs1 && (rs1 != 5'd0);
      reads_rs2 = op_rs2 && (rs2 != 5'd0);
      rs1_ready = (cnt_q[rs1] == '0) ||
                  ((cnt_q[rs1] == CNT_W'(1)) && wb_valid && (wb_rd == rs1));
      rs2_ready = (cnt_q[rs2] == '0) ||
                  ((cnt_q[rs2] == CNT_W'(1)) && wb_valid && (wb_rd == rs2));
      rd_sat    = writes_rd && (cnt_q[rd] == CNT_MAX) && !(wb_valid && (wb_rd == rd));
      hazard    = (reads_rs1 && !rs1_ready) || (reads_rs2 && !rs2_ready) || rd_sat;
   end

   // Pipeline strobes, forced low while reset is held
   always_comb begin
      flush = !rst && (ex_redirect || (state_q == ST_FLUSH));
      issue = !rst && id_valid && (state_q == ST_RUN) && !ex_redirect && !hazard;
      stall = !rst && id_valid && (state_q == ST_RUN) && !ex_redirect &&  hazard;
   end

   // Flush sequencer: counts remaining flush cycles, a new redirect restarts the count
   always_comb begin
      state_d = state_q;
      fcnt_d  = fcnt_q;
      if (ex_redirect && (FLUSH_CYCLES != 0)) begin
         state_d = ST_FLUSH;
         fcnt_d  = FC_LOAD;
      end else if (state_q == ST_FLUSH) begin
         fcnt_d = fcnt_q - FC_W'(1);
         if (fcnt_q <= FC_W'(1)) begin
            state_d = ST_RUN;
            fcnt_d  = '0;
         end
      end
   end

   // Scoreboard update: issue increments, writeback decrements, both cancel out
   always_comb begin
      sb_err_d = sb_err_q || (wb_valid && (wb_rd != 5'd0) && (cnt_q[wb_rd] == '0));
      cnt_d[0] = '0;
      sb_busy  = '0;
      for (int i = 1; i < 32; i++) begin
         logic inc, dec;
         inc = issue && writes_rd && (rd == 5'(i));
         dec = wb_valid && (wb_rd == 5'(i)) && (cnt_q[i] != '0);
         cnt_d[i]   = cnt_q[i];
         if (inc && !dec)      cnt_d[i] = cnt_q[i] + CNT_W'(1);
         else if (dec && !inc) cnt_d[i] = cnt_q[i] - CNT_W'(1);
         sb_busy[i] = (cnt_q[i] != '0);
      end
   end

   assign sb_err = sb_err_q;

   // State registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_RUN;
         fcnt_q   <= '0;
         sb_err_q <= 1'b0;
         for (int i = 0; i < 32; i++) cnt_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         fcnt_q   <= fcnt_d;
         sb_err_q <= sb_err_d;
         for (int i = 0; i < 32; i++) cnt_q[i] <= cnt_d[i];
      end
   end

endmodule

// File: tb/tb_rv_hazard_ctrl.sv
// tb/tb_rv_hazard_ctrl.sv - scoreboard bench for rv_hazard_ctrl
module tb_rv_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        id_valid = 1'b0;
   logic [31:0] if_id_ir = '0;
   logic        ex_redirect = 1'b0;
   logic        wb_valid = 1'b0;
   logic [4:0]  wb_rd = '0;
   logic        issue, stall, flush, sb_err;
   logic [31:0] sb_busy;

   rv_hazard_ctrl #(.CNT_W(2), .FLUSH_CYCLES(1)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .if_id_ir(if_id_ir),
      .ex_redirect(ex_redirect), .wb_valid(wb_valid), .wb_rd(wb_rd),
      .issue(issue), .stall(stall), .flush(flush),
      .sb_busy(sb_busy), .sb_err(sb_err)
   );

   always #5 clk = ~clk;

   localparam logic [31:0] ADDI_X4 = 32'h0010_0213;
   localparam logic [31:0] LW_X5   = 32'h0002_2283;
   localparam logic [31:0] ADDI_X0 = 32'h0010_0013;
   localparam logic [31:0] SW_X0   = 32'h0000_2023;
   localparam logic [31:0] ADDI_X6 = 32'h0010_0313;
   localparam logic [31:0] ADDI_X7 = 32'h0010_0393;
   localparam logic [31:0] ILL_X4  = 32'h0002_007F;

   typedef struct {
      int          step;
      logic        iss;
      logic        stl;
      logic        fl;
      logic [31:0] busy;
      logic        err;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   step_no  = 0;

   function automatic void chk(input int stp, input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL step %0d %s: got 0x%08h expected 0x%08h", stp, nm, act, exp);
      end
   endfunction

   // Monitor: every cycle the DUT presents its strobes; compare against the oldest expectation
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk(e.step, "issue",   32'(issue),  32'(e.iss));
         chk(e.step, "stall",   32'(stall),  32'(e.stl));
         chk(e.step, "flush",   32'(flush),  32'(e.fl));
         chk(e.step, "sb_busy", sb_busy,     e.busy);
         chk(e.step, "sb_err",  32'(sb_err), 32'(e.err));
      end
   end

   task automatic step(input logic r, input logic v, input logic [31:0] ir, input logic rdr,
                       input logic wv, input logic [4:0] wr,
                       input logic ei, input logic es, input logic ef,
                       input logic [31:0] eb, input logic ee);
      exp_t e;
      @(posedge clk);
      #1;
      rst = r; id_valid = v; if_id_ir = ir; ex_redirect = rdr; wb_valid = wv; wb_rd = wr;
      step_no++;
      e.step = step_no; e.iss = ei; e.stl = es; e.fl = ef; e.busy = eb; e.err = ee;
      exp_q.push_back(e);
   endtask

   initial begin
      //   rst v  ir       rdr wv wr  | iss stl fl busy          err
      // reset holds strobes low even with a redirect and valid ID
      step(1, 1, ADDI_X4, 1, 0, 0,    0, 0, 0, 32'h0,        0);
      // RAW stall on x4 until its writeback
      step(0, 1, ADDI_X4, 0, 0, 0,    1, 0, 0, 32'h0,        0);
      step(0, 1, LW_X5,   0, 0, 0,    0, 1, 0, 32'h10,       0);
      step(0, 1, LW_X5,   0, 0, 0,    0, 1, 0, 32'h10,       0);
      step(0, 1, LW_X5,   0, 1, 4,    1, 0, 0, 32'h10,       0);
      step(0, 0, 32'h0,   0, 0, 0,    0, 0, 0, 32'h20,       0);
      // x0 is never tracked
      step(0, 1, ADDI_X0, 0, 1, 5,    1, 0, 0, 32'h20,       0);
      step(0, 1, SW_X0,   0, 0, 0,    1, 0, 0, 32'h0,        0);
      step(0, 0, 32'h0,   0, 0, 0,    0, 0, 0, 32'h0,        0);
      // redirect: two flush cycles, then issue resumes
      step(0, 1, ADDI_X4, 1, 0, 0,    0, 0, 1, 32'h0,        0);
      step(0, 1, ADDI_X4, 0, 0, 0,    0, 0, 1, 32'h0,        0);
      step(0, 1, ADDI_X4, 0, 0, 0,    1, 0, 0, 32'h0,        0);
      step(0, 0, 32'h0,   0, 1, 4,    0, 0, 0, 32'h10,       0);
      // counter saturation on x6
      step(0, 1, ADDI_X6, 0, 0, 0,    1, 0, 0, 32'h0,        0);
      step(0, 1, ADDI_X6, 0, 0, 0,    1, 0, 0, 32'h40,       0);
      step(0, 1, ADDI_X6, 0, 0, 0,    1, 0, 0, 32'h40,       0);
      step(0, 1, ADDI_X6, 0, 0, 0,    0, 1, 0, 32'h40,       0);
      step(0, 1, ADDI_X6, 0, 1, 6,    1, 0, 0, 32'h40,       0);
      step(0, 0, 32'h0,   0, 1, 6,    0, 0, 0, 32'h40,       0);
      step(0, 0, 32'h0,   0, 1, 6,    0, 0, 0, 32'h40,       0);
      step(0, 0, 32'h0,   0, 1, 6,    0, 0, 0, 32'h40,       0);
      step(0, 0, 32'h0,   0, 0, 0,    0, 0, 0, 32'h0,        0);
      // same-cycle issue and writeback on x7 leaves the count unchanged
      step(0, 1, ADDI_X7, 0, 0, 0,    1, 0, 0, 32'h0,        0);
      step(0, 1, ADDI_X7, 0, 1, 7,    1, 0, 0, 32'h80,       0);
      step(0, 0, 32'h0,   0, 0, 0,    0, 0, 0, 32'h80,       0);
      step(0, 0, 32'h0,   0, 1, 7,    0, 0, 0, 32'h80,       0);
      // writeback to x0 is not an error; writeback to idle x9 is, and it sticks
      step(0, 0, 32'h0,   0, 1, 0,    0, 0, 0, 32'h0,        0);
      step(0, 0, 32'h0,   0, 1, 9,    0, 0, 0, 32'h0,        0);
      step(0, 1, ADDI_X4, 0, 0, 0,    1, 0, 0, 32'h0,        1);
      // reset asserted during FLUSH clears everything at once
      step(0, 1, ADDI_X4, 1, 0, 0,    0, 0, 1, 32'h10,       1);
      step(1, 1, ADDI_X4, 0, 0, 0,    0, 0, 0, 32'h0,        0);
      step(0, 0, 32'h0,   0, 0, 0,    0, 0, 0, 32'h0,        0);
      step(0, 1, ADDI_X4, 0, 0, 0,    1, 0, 0, 32'h0,        0);
      // illegal opcode issues as NOP even though its rs1 field names busy x4
      step(0, 1, ILL_X4,  0, 0, 0,    1, 0, 0, 32'h10,       0);
      step(0, 0, 32'h0,   0, 0, 0,    0, 0, 0, 32'h10,       0);

      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
      if (exp_q.size() > 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
